// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state types shared by the sequential ALU.
package alu_seq_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_XOR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIV  = 3'd7
  } op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_iter(input op_t op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: one-bit-per-cycle shift-add multiplier / restoring divider sharing one datapath.
module alu_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, mq, dv, acc_n, mq_n;
  logic [WIDTH:0] sum, trial, diff;
  logic div, dz;
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, (mq[0] ? dv : '0)};
    trial = {acc, mq[WIDTH-1]};
    diff  = trial - {1'b0, dv};
    // A zero divisor freezes the preloaded {a, all-ones} pair for the whole run
    acc_n = dz ? acc : !div ? sum[WIDTH:1] : diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    mq_n  = dz ? mq : !div ? {sum[0], mq[WIDTH-1:1]} : {mq[WIDTH-2:0], ~diff[WIDTH]};
  end
  // Outputs are the post-step values so the final step and result capture share an edge
  assign done      = cnt == CW'(1);
  assign product   = {acc_n, mq_n};
  assign quotient  = mq_n;
  assign remainder = acc_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      mq  <= '0;
      dv  <= '0;
      div <= 1'b0;
      dz  <= 1'b0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      acc <= (is_div && b == '0) ? a : '0;
      mq  <= (is_div && b == '0) ? '1 : a;
      dv  <= b;
      div <= is_div;
      dz  <= is_div && b == '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= acc_n;
      mq  <= mq_n;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; logic/add/sub in one cycle, MUL/DIV iterate one bit per cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);
  state_t state, state_n;
  op_t op_i, op_r;
  logic bz_r, fire, start, it_done;
  logic [2*WIDTH-1:0] product, simple;
  logic [WIDTH-1:0] quo, rem, lg;
  logic [WIDTH:0] sum, diff;
  assign op_i = op_t'(op);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    fire      = in_valid && in_ready;
    start     = fire && is_iter(op_i);
    lg   = op_i == OP_AND ? a & b : op_i == OP_OR ? a | b : op_i == OP_NAND ? ~(a & b) : a ^ b;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    simple = op_i == OP_ADD ? {{(WIDTH-1){1'b0}}, sum} :
             op_i == OP_SUB ? {{(WIDTH-1){diff[WIDTH]}}, diff} : {{WIDTH{1'b0}}, lg};
    state_n = (state == IDLE && fire) ? (is_iter(op_i) ? BUSY : DONE) :
              (state == BUSY && it_done) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_r     <= OP_AND;
      bz_r     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else if (fire) begin
      op_r <= op_i;
      bz_r <= b == '0;
      if (!is_iter(op_i)) begin
        result   <= simple;
        div_zero <= 1'b0;
      end
    end else if (state == BUSY && it_done) begin
      result   <= op_r == OP_DIV ? {rem, quo} : product;
      div_zero <= op_r == OP_DIV && bz_r;
    end
  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_div    (op_i == OP_DIV),
    .a         (a),
    .b         (b),
    .done      (it_done),
    .product   (product),
    .quotient  (quo),
    .remainder (rem)
  );
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomised checks of alu_seq at WIDTH=8.
module tb_alu_seq;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = 0, b = 0;
  logic [2:0] op = 0;
  logic in_ready, out_valid, div_zero;
  logic [2*W-1:0] result;
  int errors = 0, checks = 0, lat;
  bit ready_in_busy;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0: return {9'd0, x & y};
      3'd1: return {9'd0, x | y};
      3'd2: return {9'd0, ~(x & y)};
      3'd3: return {9'd0, x ^ y};
      3'd4: return {1'b0, 16'(x) + 16'(y)};
      3'd5: return {1'b0, 16'(x) - 16'(y)};
      3'd6: return {1'b0, 16'(x) * 16'(y)};
      default: return y == 0 ? {1'b1, x, 8'hFF} : {1'b0, x % y, x / y};
    endcase
  endfunction

  // Drives one transaction, scrambles inputs after acceptance, returns at the negedge out_valid rises
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 0; a = ~x; b = ~y; op = ~o;
    lat = 0;
    ready_in_busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) ready_in_busy = 1;
    end while (!out_valid && lat < 100);
  endtask

  task automatic accept;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset result got=%h exp=0000", result); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset div_zero got=%b exp=0", div_zero); end
    rst_n = 1;
  endtask

  task automatic test_simple;
    logic [2:0]  ops [9] = '{3'd4, 3'd2, 3'd5, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd5};
    logic [7:0]  as  [9] = '{8'hFF, 8'hF0, 8'h03, 8'hF0, 8'hF0, 8'hF0, 8'h80, 8'h05, 8'h00};
    logic [7:0]  bs  [9] = '{8'h01, 8'hCC, 8'h05, 8'hCC, 8'hCC, 8'hCC, 8'h80, 8'h03, 8'hFF};
    logic [15:0] exp [9] = '{16'h0100, 16'h003F, 16'hFFFE, 16'h00C0, 16'h00FC, 16'h003C, 16'h0100, 16'h0002, 16'hFF01};
    for (int i = 0; i < 9; i++) begin
      send(ops[i], as[i], bs[i]);
      checks++; if (lat !== 1) begin errors++; $display("FAIL simple[%0d] latency got=%0d exp=1", i, lat); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL simple[%0d] result got=%h exp=%h", i, result, exp[i]); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL simple[%0d] div_zero got=%b exp=0", i, div_zero); end
      accept();
    end
  endtask

  task automatic test_muldiv;
    logic [2:0]  ops [8] = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd7};
    logic [7:0]  as  [8] = '{8'd200, 8'hFF, 8'd100, 8'd37, 8'hFF, 8'h05, 8'h00, 8'hFF};
    logic [7:0]  bs  [8] = '{8'd100, 8'hFF, 8'd7, 8'd0, 8'h01, 8'h09, 8'hFF, 8'h00};
    logic [15:0] exp [8] = '{16'h4E20, 16'hFE01, 16'h020E, 16'h25FF, 16'h00FF, 16'h0500, 16'h0000, 16'hFFFF};
    logic        dz  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      send(ops[i], as[i], bs[i]);
      checks++; if (lat !== 9) begin errors++; $display("FAIL muldiv[%0d] latency got=%0d exp=9", i, lat); end
      checks++; if (ready_in_busy) begin errors++; $display("FAIL muldiv[%0d] in_ready high while busy got=1 exp=0", i); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL muldiv[%0d] result got=%h exp=%h", i, result, exp[i]); end
      checks++; if (div_zero !== dz[i]) begin errors++; $display("FAIL muldiv[%0d] div_zero got=%b exp=%b", i, div_zero, dz[i]); end
      accept();
    end
  endtask

  task automatic test_backpressure;
    send(3'd4, 8'h0A, 8'h14);
    op = 3'd4; a = 8'h01; b = 8'h01; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h001E || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got ov=%b res=%h rdy=%b exp ov=1 res=001e rdy=0", i, out_valid, result, in_ready);
      end
    end
    accept();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL after_accept got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready); end
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 16'h0002) begin errors++; $display("FAIL second_txn got ov=%b res=%h exp ov=1 res=0002", out_valid, result); end
    accept();
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    op = 3'd6; a = 8'd200; b = 8'd100; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_before_reset in_ready got=%b exp=0", in_ready); end
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready); end
    checks++; if (result !== 16'h0 || div_zero !== 1'b0) begin errors++; $display("FAIL mid_reset got res=%h dz=%b exp res=0000 dz=0", result, div_zero); end
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL discarded got ov=%b exp=0", out_valid); end
    send(3'd4, 8'd2, 8'd2);
    checks++; if (lat !== 1 || result !== 16'h0004) begin errors++; $display("FAIL post_reset_add got lat=%0d res=%h exp lat=1 res=0004", lat, result); end
    accept();
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [7:0] x, y;
    logic [16:0] e;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      e = model(o, x, y);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(o, x, y);
      checks++; if (lat !== (o >= 3'd6 ? 9 : 1)) begin errors++; $display("FAIL rand[%0d] op=%0d latency got=%0d", i, o, lat); end
      checks++; if (result !== e[15:0] || div_zero !== e[16]) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h got res=%h dz=%b exp res=%h dz=%b", i, o, x, y, result, div_zero, e[15:0], e[16]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rand[%0d] duplicate got ov=%b rdy=%b", i, out_valid, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_muldiv();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit combinational ALU. Accepts one operand pair plus 3-bit opcode per transaction over a valid/ready interface. Logic/add/subtract complete in one cycle; multiply and divide run iteratively, one bit per cycle. Sits between the operand/keypad front end and the display/result register path.

## Interface
- WIDTH, 8, operand width in bits (≥2); result is 2*WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block can accept a transaction
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- op  in  3  0 AND, 1 OR, 2 NAND, 3 XOR, 4 ADD, 5 SUB, 6 MUL, 7 DIV
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  2*WIDTH  result word
- div_zero  out  1  qualifies result: DIV with b==0

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid: latch a, b, op. Ops 0–5 → result computed, go DONE. Ops 6–7 → load iteration count, go BUSY.
- BUSY: in_ready=0; one shift-add (MUL) or restoring-subtract (DIV) step per cycle; after WIDTH steps go DONE.
- DONE: out_valid=1; result, div_zero held stable until out_ready sampled high; then go IDLE.
- Result formatting:
  - Logic ops: WIDTH-bit result zero-extended.
  - ADD: WIDTH+1-bit sum zero-extended.
  - SUB: a−b as two's complement, sign-extended to 2*WIDTH.
  - MUL: full 2*WIDTH product.
  - DIV: {remainder, quotient}, each WIDTH bits.
- Divide by zero: quotient all ones, remainder = a, div_zero=1, same latency as normal DIV. div_zero is 0 for every other result.
- Inputs are ignored when in_ready=0. a/b/op changes while BUSY have no effect.

## Timing
- Reset (async assert, sync deassert assumed upstream): state IDLE, in_ready=1, out_valid=0, result=0, div_zero=0, iteration counter=0.
- Handshake at edge E (in_valid & in_ready):
  - Ops 0–5: out_valid=1 from E+1.
  - Ops 6–7: out_valid=1 from E+WIDTH+1.
- Output accepted at edge F (out_valid & out_ready): out_valid=0 and in_ready=1 from F+1. Next acceptance is earliest at F+1. Peak throughput is one simple op per 2 cycles.
- out_ready is ignored while out_valid=0. in_ready is never high together with out_valid.
- Reset mid-BUSY or mid-DONE: transaction discarded, outputs return to reset values immediately.
- result retains its last value in IDLE/BUSY; only out_valid qualifies it.

## Structure
- Package alu_seq_pkg: op enum (OP_AND…OP_DIV with the fixed encodings above), state enum (IDLE/BUSY/DONE).
- Sub-module alu_seq_iter: shared shift register, accumulator and counter for MUL/DIV.
  - Ports: start, is_div, a, b, done, product/quotient/remainder.
  - Owns the divide-by-zero substitution.
- Top module: FSM, operand latch, single-cycle ops, output register.

## Test plan
- WIDTH=8, ADD a=0xFF, b=0x01 → result=0x0100 one cycle after accept. NAND a=0xF0, b=0xCC → 0x003F. SUB a=3, b=5 → 0xFFFE.
- MUL a=200, b=100 → result=0x4E20, out_valid exactly 9 cycles after accept, in_ready=0 throughout BUSY.
- DIV a=100, b=7 → result=0x020E, div_zero=0. DIV a=37, b=0 → result=0x25FF, div_zero=1, same 9-cycle latency.
- Backpressure: out_ready held low 5 cycles after out_valid → result and out_valid stable. A second in_valid is not accepted until the cycle after the out_ready handshake.
- Reset: assert rst_n=0 at BUSY cycle 4 of a MUL → out_valid=0, in_ready=1, result=0 immediately. A new ADD 2+2 after release returns 0x0004.
- Random sweep WIDTH=4 and WIDTH=8, all ops, random in_valid/out_ready gaps → scoreboard matches reference model, no lost or duplicated transactions.
